// File: rtl/tensor_mem_ctrl.sv
// Tensor memory controller: byte-enable word RAM behind a valid/ready request port,
// fixed-latency read pipeline, credit-managed response FIFO and a bulk-clear engine.
module tensor_mem_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_byteen,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  input  logic                    clear_start,
  output logic                    busy,
  output logic                    clear_done
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;
  localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW    = PW + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     clr_addr_q, clr_addr_d;
  logic                    clear_done_q, clear_done_d;
  logic                    run_q, run_d;
  logic [CW-1:0]           credits_q, credits_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] pipe_data [READ_LATENCY];
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

  logic                  rd_acc, wr_acc, push, pop, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;

  // run_q keeps the request port closed until the first edge after reset release
  assign req_ready  = run_q && (state_q == IDLE) && !clear_start && (credits_q != '0);
  assign rsp_valid  = (cnt_q != '0);
  assign rsp_data   = rsp_valid ? fifo_mem[rd_ptr_q] : '0;
  assign busy       = (state_q == CLEAR);
  assign clear_done = clear_done_q;

  assign rd_acc = req_valid && req_ready && !req_write;
  assign wr_acc = req_valid && req_ready && req_write;
  assign push   = vld_q[READ_LATENCY-1];
  assign pop    = rsp_valid && rsp_ready;

  always_comb begin
    run_d     = 1'b1;
    vld_d     = READ_LATENCY'({vld_q, rd_acc});
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    credits_d = credits_q;
    case ({rd_acc, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clear_done_d = 1'b0;
    mem_we       = wr_acc;
    mem_addr     = req_addr;
    mem_wdata    = req_wdata;
    mem_be       = req_byteen;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        mem_we     = 1'b1;
        mem_addr   = clr_addr_q[ADDR_WIDTH-1:0];
        mem_wdata  = '0;
        mem_be     = '1;
        clr_addr_d = clr_addr_q + (ADDR_WIDTH+1)'(1);
        // Carry into the extra counter bit marks the last word without wrapping
        if (clr_addr_d[ADDR_WIDTH]) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      clr_addr_q   <= '0;
      clear_done_q <= 1'b0;
      run_q        <= 1'b0;
      credits_q    <= CW'(RSP_DEPTH);
      vld_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clear_done_q <= clear_done_d;
      run_q        <= run_d;
      credits_q    <= credits_d;
      vld_q        <= vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Datapath storage is not reset; the FIFO head is masked by the occupancy count
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    pipe_data[0] <= mem[req_addr];
    for (int k = 1; k < READ_LATENCY; k++) pipe_data[k] <= pipe_data[k-1];
    if (push) fifo_mem[wr_ptr_q] <= pipe_data[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_tensor_mem_ctrl.sv
// Randomized and directed bench for tensor_mem_ctrl, checked cycle by cycle against
// a transaction-level model (word array, in-order response queue, clear progress).
module tb_tensor_mem_ctrl;
  localparam int AW = 8, DW = 32, LAT = 2, RD = 4, DEPTH = 256, BW = 4;

  logic          clock = 1'b0, reset_n = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_byteen = '0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          clear_start = 1'b0, busy, clear_done;

  always #5 clock = ~clock;

  tensor_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT), .RSP_DEPTH(RD)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done)
  );

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int            exp_t[$];
  bit            clr_m = 0, done_m = 0, rdy_m = 0, last_acc = 0;
  int            clr_idx = 0, edge_n = 0;

  // Observation counters
  int            busy_cnt = 0, done_cnt = 0, dut_acc_cnt = 0, rdy_busy_cnt = 0;
  int            rv_cnt = 0, rv_first = -1, rv_last = -1;
  logic [DW-1:0] last_pop = '0;

  // Inputs are set at a negedge; sample at +1, then apply the model at the posedge.
  task automatic cycle();
    bit            exp_rdy, exp_rv, acc, pop_now;
    logic [DW-1:0] exp_rd;
    #1;
    exp_rdy = rdy_m && !clr_m && !clear_start && (exp_q.size() < RD);
    exp_rv  = (exp_q.size() > 0) && (exp_t[0] + LAT <= edge_n);
    exp_rd  = exp_rv ? exp_q[0] : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("rsp_data", rsp_data, exp_rd);
    check("busy", 32'(busy), 32'(clr_m));
    check("clear_done", 32'(clear_done), 32'(done_m));
    if (busy) busy_cnt++;
    if (busy && req_ready) rdy_busy_cnt++;
    if (clear_done) done_cnt++;
    if (req_valid && req_ready) dut_acc_cnt++;
    if (rsp_valid) begin
      rv_cnt++;
      if (rv_first < 0) rv_first = edge_n;
      rv_last = edge_n;
    end
    acc      = req_valid && exp_rdy;
    pop_now  = exp_rv && rsp_ready;
    if (pop_now) last_pop = rsp_data;
    last_acc = acc;
    @(posedge clock);
    edge_n++;
    rdy_m  = 1;
    done_m = 0;
    if (pop_now) begin
      $display("rsp data=%08h", exp_q[0]);
      void'(exp_q.pop_front());
      void'(exp_t.pop_front());
    end
    if (clr_m) begin
      ref_mem[clr_idx] = '0;
      clr_idx++;
      if (clr_idx == DEPTH) begin
        clr_m  = 0;
        done_m = 1;
      end
    end else if (clear_start) begin
      clr_m   = 1;
      clr_idx = 0;
    end
    if (acc) begin
      if (req_write) begin
        $display("req wr addr=%02h data=%08h be=%h", req_addr, req_wdata, req_byteen);
        for (int i = 0; i < BW; i++)
          if (req_byteen[i]) ref_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
      end else begin
        $display("req rd addr=%02h", req_addr);
        exp_q.push_back(ref_mem[req_addr]);
        exp_t.push_back(edge_n);
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    req_valid = 0; clear_start = 0;
    reset_n = 0;
    exp_q.delete(); exp_t.delete();
    clr_m = 0; done_m = 0; rdy_m = 0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", rsp_data, '0);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_clear_done", 32'(clear_done), 32'(0));
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic issue(input bit wr, input int addr, input logic [DW-1:0] data, input logic [BW-1:0] be);
    req_valid = 1; req_write = wr; req_addr = AW'(addr); req_wdata = data; req_byteen = be;
    for (int n = 0; n < 300; n++) begin
      cycle();
      if (last_acc) break;
    end
    check("issue_acc", 32'(last_acc), 32'(1));
    req_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && exp_q.size() > 0; n++) cycle();
    check("drain", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic read_expect(input string tag, input int addr, input logic [DW-1:0] exp);
    rsp_ready = 1;
    issue(0, addr, '0, '0);
    drain();
    check(tag, last_pop, exp);
  endtask

  task automatic fill(input logic [DW-1:0] val);
    rsp_ready = 1;
    for (int a = 0; a < DEPTH; a++) issue(1, a, val, '1);
  endtask

  task automatic wait_clear();
    for (int n = 0; n < 400 && clr_m; n++) cycle();
    check("clear_finished", 32'(clr_m), 32'(0));
    cycle();
  endtask

  initial begin
    int acc_edge;
    @(negedge clock);
    do_reset();
    cycle();
    fill(32'hFFFF_FFFF);

    // Byte-enable merge and read latency
    issue(1, 5, 32'hAABBCCDD, 4'hF);
    issue(1, 5, 32'h11223344, 4'b0101);
    rv_cnt = 0; rv_first = -1;
    issue(0, 5, '0, '0);
    acc_edge = edge_n;
    drain();
    check("be_merge", last_pop, 32'hAA22CC44);
    check("be_latency", 32'(rv_first - acc_edge), 32'(LAT));

    // Streaming reads
    for (int k = 0; k < 8; k++) issue(1, k, DW'(k), '1);
    cycle(); cycle();
    dut_acc_cnt = 0; rv_cnt = 0; rv_first = -1; rv_last = -1;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1; req_write = 0; req_addr = AW'(k);
      cycle();
    end
    req_valid = 0;
    drain();
    check("stream_acc", 32'(dut_acc_cnt), 32'(8));
    check("stream_rsp_cnt", 32'(rv_cnt), 32'(8));
    check("stream_rsp_span", 32'(rv_last - rv_first + 1), 32'(8));

    // Backpressure
    rsp_ready = 0; dut_acc_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1; req_write = 0; req_addr = AW'(k);
      cycle();
    end
    #1;
    check("bp_rdy_low", 32'(req_ready), 32'(0));
    check("bp_accepted", 32'(dut_acc_cnt), 32'(4));
    req_valid = 0; rsp_ready = 1;
    drain();
    issue(0, 4, '0, '0);
    issue(0, 5, '0, '0);
    drain();
    check("bp_last", last_pop, 32'd5);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      req_valid   = ($urandom_range(0, 9) < 7);
      req_write   = 1'($urandom_range(0, 1));
      req_addr    = AW'($urandom_range(0, 15));
      req_wdata   = $urandom();
      req_byteen  = BW'($urandom_range(0, 15));
      rsp_ready   = ($urandom_range(0, 9) < 7);
      clear_start = ($urandom_range(0, 399) == 0);
      cycle();
    end
    clear_start = 0; req_valid = 0; rsp_ready = 1;
    wait_clear();
    drain();

    // Bulk clear
    fill(32'hFFFF_FFFF);
    busy_cnt = 0; done_cnt = 0; rdy_busy_cnt = 0;
    clear_start = 1; cycle(); clear_start = 0;
    for (int n = 0; n < 300; n++) cycle();
    check("clr_busy_cycles", 32'(busy_cnt), 32'(256));
    check("clr_done_pulses", 32'(done_cnt), 32'(1));
    check("clr_rdy_busy", 32'(rdy_busy_cnt), 32'(0));
    read_expect("clr_a0", 0, '0);
    read_expect("clr_a128", 128, '0);
    read_expect("clr_a255", 255, '0);

    // Clear/request collision
    issue(1, 7, 32'h12345678, '1);
    clear_start = 1; req_valid = 1; req_write = 0; req_addr = 8'd7;
    #1;
    check("coll_rdy", 32'(req_ready), 32'(0));
    cycle();
    clear_start = 0; req_valid = 0;
    wait_clear();
    read_expect("coll_read", 7, '0);

    // Reset during clear with reads in flight
    fill(32'hFFFF_FFFF);
    rsp_ready = 0;
    issue(0, 1, '0, '0);
    issue(0, 2, '0, '0);
    clear_start = 1; cycle(); clear_start = 0;
    for (int n = 0; n < 200 && clr_m && clr_idx < 100; n++) cycle();
    check("rst_at_100", 32'(clr_idx), 32'(100));
    do_reset();
    rsp_ready = 1;
    rv_cnt = 0;
    for (int n = 0; n < 6; n++) cycle();
    check("rst_no_rsp", 32'(rv_cnt), 32'(0));
    rsp_ready = 0; dut_acc_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1; req_write = 0; req_addr = AW'(k + 10);
      cycle();
    end
    req_valid = 0;
    check("rst_credits", 32'(dut_acc_cnt), 32'(4));
    rsp_ready = 1;
    drain();
    for (int a = 0; a < 100; a++) read_expect("rst_zeroed", a, '0);
    read_expect("rst_a100", 100, 32'hFFFF_FFFF);
    read_expect("rst_a200", 200, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tensor_mem_ctrl.md
Name: tensor_mem_ctrl

Overview:
Parametrised on-chip tensor memory controller. It is the successor to the fixed 256x32 single-cycle M10K wrapper and stand-in memory. It adds:
- a valid/ready request channel with per-byte write enables;
- a configurable read-latency pipeline;
- a credit-managed response FIFO that absorbs consumer backpressure;
- a hardware bulk-clear engine.

It sits between the matrix/tensor compute engines and the inferred M10K array.

Parameters:
ADDR_WIDTH, 8, word address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; must be a multiple of 8
READ_LATENCY, 2, cycles from read acceptance to rsp_valid; legal 1..4
RSP_DEPTH, 4, response FIFO entries; power of 2, >= READ_LATENCY

Ports:
clock  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_byteen  in  DATA_WIDTH/8  byte-lane write enables; ignored on reads
rsp_valid  out  1  response word available at FIFO head
rsp_ready  in  1  consumer takes response when rsp_valid & rsp_ready
rsp_data  out  DATA_WIDTH  FIFO head; 0 when FIFO empty
clear_start  in  1  pulse: zero the entire array
busy  out  1  clear engine active
clear_done  out  1  one-cycle pulse after the last clear write

Behaviour:
- Reset (async assert, sync-to-clock release):
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=0, clear_done=0;
  - read pipeline flushed, FIFO emptied, credits=RSP_DEPTH, state=IDLE;
  - memory array contents are NOT reset.
- States: IDLE, CLEAR.
  - IDLE->CLEAR on clear_start.
  - CLEAR->IDLE on the cycle after the write to address 2**ADDR_WIDTH-1.
  - clear_start in CLEAR is ignored.
- req_ready = (state==IDLE) & ~clear_start & (credits!=0). It is combinational and does not depend on req_valid. Writes are also gated by credits, for simplicity.
- Credits:
  - decrement on an accepted read; increment on a response handshake;
  - both in the same cycle: unchanged;
  - never exceed RSP_DEPTH or go below 0, so the FIFO cannot overflow.
- Write at accepted edge T:
  - for each lane i with req_byteen[i]=1, mem[addr][8i+7:8i] <= wdata lane;
  - lanes with byteen=0 are unchanged;
  - byteen=0 entirely is a legal no-op that still consumes the handshake.
- Read accepted at edge T:
  - array sampled at edge T (write-first across edges: a read in cycle T+1 after a write at T returns the new data);
  - data enters the FIFO such that rsp_valid=1 in cycle T+READ_LATENCY when the FIFO was empty.
- Responses are returned strictly in request order. Back-to-back reads sustain 1/cycle while rsp_ready=1.
- rsp_ready low: the FIFO fills; req_ready drops once in-flight + stored reads == RSP_DEPTH.
- Clear sequencing:
  - in CLEAR, one word/cycle is written with all bytes =0, at addresses 0..2**ADDR_WIDTH-1 ascending;
  - busy=1 throughout CLEAR; clear_done=1 for exactly one cycle as the FSM returns to IDLE.
- Clear interactions:
  - Reads accepted before clear_start complete normally with pre-clear data.
  - The response path keeps draining during CLEAR.
  - clear_start and req_valid in the same IDLE cycle: clear wins, and the request is not accepted (req_ready=0).
- reset_n asserted mid-clear: the clear aborts; already-zeroed words stay zero; the remaining words are untouched.
- Address arithmetic: the clear counter is ADDR_WIDTH+1 bits wide to detect the end without wrap. req_addr is used directly; there is no out-of-range case.

Test Plan:
- Byte-enable write then read: write addr 5 data 32'hAABBCCDD byteen 4'hF; write addr 5 data 32'h11223344 byteen 4'b0101; read addr 5 -> rsp_data 32'hAA22CC44, rsp_valid exactly 2 cycles after read acceptance (READ_LATENCY=2).
- Streaming reads: pre-write addr k with data k for k=0..7; 8 back-to-back reads, rsp_ready=1 -> 8 responses 0..7 in order on consecutive cycles; req_ready never drops.
- Backpressure: rsp_ready=0, issue 6 reads -> exactly 4 accepted (RSP_DEPTH=4) and req_ready=0; raise rsp_ready -> 4 responses in order, then the remaining 2 are accepted and returned.
- Clear: fill all 256 words with 32'hFFFFFFFF; pulse clear_start -> busy=1 for 256 cycles, req_ready=0, one clear_done pulse; reads of addrs 0, 128, 255 -> 0.
- Clear/request collision: clear_start and a read both in one IDLE cycle -> the read is not accepted; a read issued after clear_done returns 0.
- Reset mid-operation: reset_n low for 1 cycle during clear at addr 100 with 2 reads in flight -> all outputs 0, no responses emerge, credits restored to 4; addrs 0..99 read 0, addr 200 reads 32'hFFFFFFFF.
